// File: rtl/fifo_arb.sv
// fifo_arb: turns STN capture bytes and TFT fetch pulses into FIFO RAM requests on one shared port.
// Optional sticky write-drop flag is built only when FIFO_ARB_OVF_EN is defined.

// Small generic queue; the caller must not push into a full queue unless it pops in the same cycle.
module fifo_arb_wq #(
  parameter int W     = 21,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_x,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx <= '0;
      rd_idx <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= din;
        wr_idx      <= wr_idx + 1'b1;
      end
      if (pop) rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_idx];
endmodule

module fifo_arb #(
  parameter int BUF_LEN = 4800
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        stn_frame_start,
  input  logic        stn_wvalid,
  input  logic [7:0]  stn_wdata,
  input  logic        tft_frame_start,
  input  logic        tft_rreq,
  output logic        tft_rready,
  output logic        tft_rvalid,
  output logic [7:0]  tft_rdata,
  output logic        ovf,
  output logic        fifo_rdreq,
  input  logic        fifo_rdack,
  output logic [12:0] fifo_raddr,
  input  logic [7:0]  fifo_rdata,
  output logic        fifo_wrreq,
  input  logic        fifo_wrack,
  output logic [12:0] fifo_waddr,
  output logic [7:0]  fifo_wdata
);
  localparam logic [12:0] LAST = 13'(BUF_LEN - 1);

  function automatic logic [12:0] wrap_inc(input logic [12:0] a);
    return (a == LAST) ? 13'd0 : a + 13'd1;
  endfunction

  logic [12:0] wptr;
  logic [12:0] rptr;
  logic [12:0] raddr_r;
  logic [12:0] waddr_use;
  logic [12:0] raddr_use;
  logic [1:0]  wq_cnt;
  logic [20:0] wq_head;
  logic        wq_full;
  logic        wr_deq;
  logic        wr_drop;
  logic        wr_acc;
  logic        rd_acc;
  logic        rd_grant;
  logic        rd_pend;
  logic        cap_en;
  logic        rvalid_r;
  logic [7:0]  rdata_r;

  // Reads win the RAM port unless the write queue is full.
  assign wq_full    = (wq_cnt == 2'd2);
  assign fifo_rdreq = rd_pend & ~wq_full;
  assign fifo_wrreq = (wq_cnt != 2'd0) & ~fifo_rdreq;
  assign rd_grant   = fifo_rdreq & fifo_rdack;
  assign wr_deq     = fifo_wrreq & fifo_wrack;

  assign wr_drop   = stn_wvalid & wq_full & ~wr_deq;
  assign wr_acc    = stn_wvalid & ~wr_drop;
  assign waddr_use = stn_frame_start ? 13'd0 : wptr;

  fifo_arb_wq #(
    .W     (21),
    .DEPTH (2)
  ) u_wq (
    .clk   (clk),
    .rst_x (rst_x),
    .push  (wr_acc),
    .pop   (wr_deq),
    .din   ({waddr_use, stn_wdata}),
    .head  (wq_head),
    .cnt   (wq_cnt)
  );

  assign fifo_waddr = wq_head[20:8];
  assign fifo_wdata = wq_head[7:0];

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      wptr <= 13'd0;
    end else if (wr_acc) begin
      wptr <= wrap_inc(waddr_use);
    end else if (stn_frame_start) begin
      wptr <= 13'd0;
    end
  end

  assign rd_acc    = tft_rreq & ~rd_pend;
  assign raddr_use = tft_frame_start ? 13'd0 : rptr;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      rptr    <= 13'd0;
      raddr_r <= 13'd0;
      rd_pend <= 1'b0;
    end else begin
      if (rd_acc) begin
        raddr_r <= raddr_use;
        rptr    <= wrap_inc(raddr_use);
        rd_pend <= 1'b1;
      end else begin
        if (tft_frame_start) rptr <= 13'd0;
        if (rd_grant) rd_pend <= 1'b0;
      end
    end
  end

  // Synchronous RAM: data for a grant appears one cycle later, then is presented the cycle after.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      cap_en   <= 1'b0;
      rvalid_r <= 1'b0;
      rdata_r  <= 8'h00;
    end else begin
      cap_en   <= rd_grant;
      rvalid_r <= cap_en;
      if (cap_en) rdata_r <= fifo_rdata;
    end
  end

  assign fifo_raddr = raddr_r;
  assign tft_rready = ~rd_pend;
  assign tft_rvalid = rvalid_r;
  assign tft_rdata  = rdata_r;

`ifdef FIFO_ARB_OVF_EN
  logic ovf_r;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      ovf_r <= 1'b0;
    end else if (wr_drop) begin
      ovf_r <= 1'b1;
    end else if (stn_frame_start) begin
      ovf_r <= 1'b0;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_arb.sv
// Bench for fifo_arb: RAM emulator plus a queue-based reference model, directed and random scenarios.
`timescale 1ns/1ps
module tb_fifo_arb;
  localparam int BUF_LEN = 4800;
`ifdef FIFO_ARB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic        stn_frame_start = 1'b0;
  logic        stn_wvalid = 1'b0;
  logic [7:0]  stn_wdata = 8'h00;
  logic        tft_frame_start = 1'b0;
  logic        tft_rreq = 1'b0;
  logic        tft_rready, tft_rvalid, ovf;
  logic [7:0]  tft_rdata;
  logic        fifo_rdreq, fifo_wrreq;
  logic        fifo_rdack = 1'b1;
  logic        fifo_wrack = 1'b1;
  logic [12:0] fifo_raddr, fifo_waddr;
  logic [7:0]  fifo_wdata;
  logic [7:0]  fifo_rdata = 8'h00;

  always #5 clk = ~clk;

  fifo_arb #(.BUF_LEN(BUF_LEN)) dut (
    .clk(clk), .rst_x(rst_x),
    .stn_frame_start(stn_frame_start), .stn_wvalid(stn_wvalid), .stn_wdata(stn_wdata),
    .tft_frame_start(tft_frame_start), .tft_rreq(tft_rreq),
    .tft_rready(tft_rready), .tft_rvalid(tft_rvalid), .tft_rdata(tft_rdata), .ovf(ovf),
    .fifo_rdreq(fifo_rdreq), .fifo_rdack(fifo_rdack), .fifo_raddr(fifo_raddr), .fifo_rdata(fifo_rdata),
    .fifo_wrreq(fifo_wrreq), .fifo_wrack(fifo_wrack), .fifo_waddr(fifo_waddr), .fifo_wdata(fifo_wdata)
  );

  // Emulated FIFO RAM with one-cycle synchronous read.
  logic [7:0] ram [8192];
  logic       ram_ready = 1'b0;
  int         wr_hs = 0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 8192; i++) ram[i] <= 8'h00;
      ram_ready <= 1'b1;
    end else begin
      if (fifo_wrreq && fifo_wrack) begin
        ram[fifo_waddr] <= fifo_wdata;
        wr_hs <= wr_hs + 1;
      end
      if (fifo_rdreq && fifo_rdack) fifo_rdata <= ram[fifo_raddr];
    end
  end

  typedef struct packed { logic [12:0] a; logic [7:0] d; } wr_t;
  wr_t        wq[$];
  logic [7:0] mmem [8192];
  int         m_wptr, m_rptr, m_raddr;
  bit         m_rd_pend, m_cap, m_rvalid, m_ovf;
  logic [7:0] m_capd, m_rdata;
  int         checks = 0;
  int         errors = 0;

  task automatic model_reset();
    wq.delete();
    m_wptr = 0; m_rptr = 0; m_raddr = 0;
    m_rd_pend = 0; m_cap = 0; m_rvalid = 0; m_ovf = 0;
    m_capd = 8'h00; m_rdata = 8'h00;
  endtask

  task automatic model_step();
    bit  rdreq, wrreq, rd_grant, wr_deq, drop;
    int  a;
    wr_t h;
    rdreq    = m_rd_pend && (wq.size() != 2);
    wrreq    = (wq.size() != 0) && !rdreq;
    rd_grant = rdreq && fifo_rdack;
    wr_deq   = wrreq && fifo_wrack;
    m_rvalid = m_cap;
    if (m_cap) m_rdata = m_capd;
    m_cap = rd_grant;
    if (rd_grant) m_capd = mmem[m_raddr];
    drop = stn_wvalid && (wq.size() == 2) && !wr_deq;
    if (wr_deq) begin
      h = wq.pop_front();
      mmem[h.a] = h.d;
    end
    if (stn_wvalid && !drop) begin
      a = stn_frame_start ? 0 : m_wptr;
      h.a = 13'(a);
      h.d = stn_wdata;
      wq.push_back(h);
      m_wptr = (a + 1) % BUF_LEN;
    end else if (stn_frame_start) begin
      m_wptr = 0;
    end
    if (drop) begin
      if (OVF_EN) m_ovf = 1;
    end else if (stn_frame_start) begin
      m_ovf = 0;
    end
    if (tft_rreq && !m_rd_pend) begin
      a = tft_frame_start ? 0 : m_rptr;
      m_raddr = a;
      m_rd_pend = 1;
      m_rptr = (a + 1) % BUF_LEN;
    end else begin
      if (tft_frame_start) m_rptr = 0;
      if (rd_grant) m_rd_pend = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stn_frame_start = 0; stn_wvalid = 0; stn_wdata = 8'h00;
    tft_frame_start = 0; tft_rreq = 0;
  endtask

  task automatic do_reset();
    rst_x = 0;
    idle_inputs();
    fifo_wrack = 1; fifo_rdack = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_x = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tft_rready !== 1'b1) begin errors++; $display("FAIL reset_rready: got %b exp 1", tft_rready); end
    checks++; if (tft_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b exp 0", tft_rvalid); end
    checks++; if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq: got %b exp 0", fifo_rdreq); end
    checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq: got %b exp 0", fifo_wrreq); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
    checks++; if (tft_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h exp 00", tft_rdata); end
    checks++; if (fifo_raddr !== 13'h0) begin errors++; $display("FAIL reset_raddr: got %h exp 0", fifo_raddr); end
    checks++; if (fifo_waddr !== 13'h0) begin errors++; $display("FAIL reset_waddr: got %h exp 0", fifo_waddr); end
    checks++; if (fifo_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h exp 00", fifo_wdata); end
  endtask

  task automatic test_write_seq();
    for (int i = 0; i < 5; i++) begin
      stn_wvalid = 1; stn_wdata = 8'hA0 + 8'(i);
      cycle();
      checks++; if (fifo_wrreq !== 1'b1) begin errors++; $display("FAIL wseq_wrreq[%0d]: got %b exp 1", i, fifo_wrreq); end
      checks++; if (fifo_waddr !== 13'(i)) begin errors++; $display("FAIL wseq_waddr[%0d]: got %h exp %h", i, fifo_waddr, 13'(i)); end
      checks++; if (fifo_wdata !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL wseq_wdata[%0d]: got %h exp %h", i, fifo_wdata, 8'hA0 + 8'(i)); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wseq_ovf[%0d]: got %b exp 0", i, ovf); end
    end
    idle_inputs();
    cycle();
    checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL wseq_drained: got %b exp 0", fifo_wrreq); end
  endtask

  task automatic test_read_latency();
    stn_frame_start = 1; stn_wvalid = 1; stn_wdata = 8'h5A;
    cycle();
    idle_inputs();
    cycle();
    tft_frame_start = 1; tft_rreq = 1;
    cycle();
    idle_inputs();
    checks++; if (fifo_rdreq !== 1'b1) begin errors++; $display("FAIL rlat_c1_rdreq: got %b exp 1", fifo_rdreq); end
    checks++; if (fifo_raddr !== 13'h0) begin errors++; $display("FAIL rlat_c1_raddr: got %h exp 0", fifo_raddr); end
    checks++; if (tft_rready !== 1'b0) begin errors++; $display("FAIL rlat_c1_rready: got %b exp 0", tft_rready); end
    cycle();
    checks++; if (tft_rready !== 1'b1) begin errors++; $display("FAIL rlat_c2_rready: got %b exp 1", tft_rready); end
    checks++; if (tft_rvalid !== 1'b0) begin errors++; $display("FAIL rlat_c2_rvalid: got %b exp 0", tft_rvalid); end
    cycle();
    checks++; if (tft_rvalid !== 1'b1) begin errors++; $display("FAIL rlat_c3_rvalid: got %b exp 1", tft_rvalid); end
    checks++; if (tft_rdata !== 8'h5A) begin errors++; $display("FAIL rlat_c3_rdata: got %h exp 5a", tft_rdata); end
    cycle();
    checks++; if (tft_rvalid !== 1'b0) begin errors++; $display("FAIL rlat_c4_rvalid: got %b exp 0", tft_rvalid); end
    checks++; if (tft_rdata !== 8'h5A) begin errors++; $display("FAIL rlat_c4_hold: got %h exp 5a", tft_rdata); end
  endtask

  task automatic test_wrap_write();
    logic [7:0] d;
    fifo_wrack = 1; fifo_rdack = 1;
    for (int k = 0; k <= BUF_LEN; k++) begin
      d = 8'($urandom);
      stn_frame_start = (k == 0); stn_wvalid = 1; stn_wdata = d;
      cycle();
      if (k == BUF_LEN - 1) begin
        checks++; if (fifo_waddr !== 13'h12BF) begin errors++; $display("FAIL wwrap_last: got %h exp 12bf", fifo_waddr); end
        checks++; if (fifo_wdata !== d) begin errors++; $display("FAIL wwrap_last_data: got %h exp %h", fifo_wdata, d); end
      end
      if (k == BUF_LEN) begin
        checks++; if (fifo_waddr !== 13'h0) begin errors++; $display("FAIL wwrap_zero: got %h exp 0", fifo_waddr); end
        checks++; if (fifo_wrreq !== 1'b1) begin errors++; $display("FAIL wwrap_wrreq: got %b exp 1", fifo_wrreq); end
      end
    end
    idle_inputs();
    repeat (3) cycle();
  endtask

  task automatic test_wrap_read();
    int n = 0;
    int cyc = 0;
    while ((n < BUF_LEN + 1 || m_rd_pend || m_cap || m_rvalid) && cyc < 20000) begin
      if (tft_rready && n < BUF_LEN + 1) begin
        tft_rreq = 1; tft_frame_start = (n == 0); n++;
      end else begin
        tft_rreq = 0; tft_frame_start = 0;
      end
      cycle();
      cyc++;
      if (fifo_rdreq && n == BUF_LEN) begin
        checks++; if (fifo_raddr !== 13'h12BF) begin errors++; $display("FAIL rwrap_last: got %h exp 12bf", fifo_raddr); end
      end
      if (fifo_rdreq && n == BUF_LEN + 1) begin
        checks++; if (fifo_raddr !== 13'h0) begin errors++; $display("FAIL rwrap_zero: got %h exp 0", fifo_raddr); end
      end
      if (m_rvalid) begin
        checks++; if (tft_rvalid !== 1'b1 || tft_rdata !== m_rdata) begin
          errors++; $display("FAIL rwrap_data: got v=%b %h exp v=1 %h", tft_rvalid, tft_rdata, m_rdata);
        end
      end
    end
    idle_inputs();
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL rwrap_timeout: cycles %0d limit 20000", cyc); end
  endtask

  task automatic test_contention();
    int base = wr_hs;
    bit seen = 0;
    fifo_wrack = 1; fifo_rdack = 1;
    for (int c = 0; c < 30; c++) begin
      stn_wvalid = 1; stn_wdata = 8'($urandom);
      tft_rreq = tft_rready;
      cycle();
      if (fifo_wrreq && !fifo_rdreq && !tft_rready) seen = 1;
      if (m_rd_pend && wq.size() == 2) begin
        checks++; if (fifo_rdreq !== 1'b0 || fifo_wrreq !== 1'b1) begin
          errors++; $display("FAIL cont_forced[%0d]: got rd=%b wr=%b exp rd=0 wr=1", c, fifo_rdreq, fifo_wrreq);
        end
      end
    end
    idle_inputs();
    repeat (10) cycle();
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL cont_seen: got %b exp 1", seen); end
    checks++; if (wr_hs - base !== 30) begin errors++; $display("FAIL cont_count: got %0d exp 30", wr_hs - base); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL cont_ovf: got %b exp 0", ovf); end
  endtask

  task automatic test_overflow();
    int base_hs, base_a;
    fifo_wrack = 0; fifo_rdack = 0;
    tft_rreq = 1;
    cycle();
    idle_inputs();
    base_hs = wr_hs;
    base_a  = m_wptr;
    for (int i = 0; i < 3; i++) begin
      stn_wvalid = 1; stn_wdata = 8'h30 + 8'(i);
      cycle();
    end
    idle_inputs();
    checks++; if (ovf !== OVF_EN) begin errors++; $display("FAIL ovf_set: got %b exp %b", ovf, OVF_EN); end
    checks++; if (fifo_wrreq !== 1'b1 || fifo_rdreq !== 1'b0) begin
      errors++; $display("FAIL ovf_full_arb: got wr=%b rd=%b exp wr=1 rd=0", fifo_wrreq, fifo_rdreq);
    end
    fifo_wrack = 1; fifo_rdack = 1;
    repeat (6) cycle();
    checks++; if (wr_hs - base_hs !== 2) begin errors++; $display("FAIL ovf_written: got %0d exp 2", wr_hs - base_hs); end
    stn_wvalid = 1; stn_wdata = 8'h77;
    cycle();
    idle_inputs();
    checks++; if (fifo_waddr !== 13'((base_a + 2) % BUF_LEN)) begin
      errors++; $display("FAIL ovf_wptr_hold: got %h exp %h", fifo_waddr, 13'((base_a + 2) % BUF_LEN));
    end
    checks++; if (ovf !== OVF_EN) begin errors++; $display("FAIL ovf_sticky: got %b exp %b", ovf, OVF_EN); end
    cycle();
    stn_frame_start = 1;
    cycle();
    idle_inputs();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", ovf); end
  endtask

  task automatic test_random();
    bit e_rdreq, e_wrreq;
    for (int c = 0; c < 3000; c++) begin
      stn_wvalid      = ($urandom_range(0, 99) < 60);
      stn_wdata       = 8'($urandom);
      stn_frame_start = ($urandom_range(0, 99) < 3);
      tft_rreq        = ($urandom_range(0, 99) < 50);
      tft_frame_start = ($urandom_range(0, 99) < 3);
      fifo_wrack      = ($urandom_range(0, 99) < 75);
      fifo_rdack      = ($urandom_range(0, 99) < 75);
      cycle();
      e_rdreq = m_rd_pend && (wq.size() != 2);
      e_wrreq = (wq.size() != 0) && !e_rdreq;
      checks++; if (fifo_rdreq !== e_rdreq) begin errors++; $display("FAIL rnd_rdreq[%0d]: got %b exp %b", c, fifo_rdreq, e_rdreq); end
      checks++; if (fifo_wrreq !== e_wrreq) begin errors++; $display("FAIL rnd_wrreq[%0d]: got %b exp %b", c, fifo_wrreq, e_wrreq); end
      if (e_rdreq) begin
        checks++; if (fifo_raddr !== 13'(m_raddr)) begin errors++; $display("FAIL rnd_raddr[%0d]: got %h exp %h", c, fifo_raddr, 13'(m_raddr)); end
      end
      if (e_wrreq) begin
        checks++; if (fifo_waddr !== wq[0].a || fifo_wdata !== wq[0].d) begin
          errors++; $display("FAIL rnd_wr[%0d]: got %h/%h exp %h/%h", c, fifo_waddr, fifo_wdata, wq[0].a, wq[0].d);
        end
      end
      checks++; if (tft_rready !== !m_rd_pend) begin errors++; $display("FAIL rnd_rready[%0d]: got %b exp %b", c, tft_rready, !m_rd_pend); end
      checks++; if (tft_rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid[%0d]: got %b exp %b", c, tft_rvalid, m_rvalid); end
      checks++; if (tft_rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h exp %h", c, tft_rdata, m_rdata); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b exp %b", c, ovf, m_ovf); end
    end
    idle_inputs();
    fifo_wrack = 1; fifo_rdack = 1;
    repeat (8) cycle();
  endtask

  task automatic test_reset_async();
    fifo_wrack = 0; fifo_rdack = 1;
    stn_wvalid = 1; stn_wdata = 8'hC3; tft_rreq = 1;
    cycle();
    idle_inputs();
    cycle();
    rst_x = 0;
    #1;
    checks++; if (tft_rready !== 1'b1) begin errors++; $display("FAIL arst_rready: got %b exp 1", tft_rready); end
    checks++; if (tft_rvalid !== 1'b0) begin errors++; $display("FAIL arst_rvalid: got %b exp 0", tft_rvalid); end
    checks++; if (fifo_rdreq !== 1'b0 || fifo_wrreq !== 1'b0) begin
      errors++; $display("FAIL arst_req: got rd=%b wr=%b exp 0 0", fifo_rdreq, fifo_wrreq);
    end
    checks++; if (fifo_waddr !== 13'h0 || fifo_wdata !== 8'h00) begin
      errors++; $display("FAIL arst_wport: got %h/%h exp 0/00", fifo_waddr, fifo_wdata);
    end
    checks++; if (fifo_raddr !== 13'h0 || tft_rdata !== 8'h00 || ovf !== 1'b0) begin
      errors++; $display("FAIL arst_misc: got raddr=%h rdata=%h ovf=%b exp 0", fifo_raddr, tft_rdata, ovf);
    end
    model_reset();
    fifo_wrack = 1;
    @(negedge clk);
    @(negedge clk);
    rst_x = 1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      checks++; if (tft_rvalid !== 1'b0 || fifo_wrreq !== 1'b0) begin
        errors++; $display("FAIL arst_after[%0d]: got rvalid=%b wrreq=%b exp 0 0", c, tft_rvalid, fifo_wrreq);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mmem[i] = 8'h00;
    test_reset();
    test_write_seq();
    test_read_latency();
    test_wrap_write();
    test_wrap_read();
    test_contention();
    test_overflow();
    test_random();
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
